// File: rtl/uart_pkg.sv
// Shared UART constants and types for the transmitter/receiver pair.
package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;

  // Start bit + data bits + stop bit.
  localparam int unsigned FRAME_LEN = DATA_WIDTH_DEFAULT + 2;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    RECOVER
  } rx_state_t;

endpackage

// File: rtl/uart_rx_hold.sv
// One-entry valid/ready holding register for received bytes.
// A completed frame arriving while the register is full and not being
// drained is dropped, and overrun pulses for one cycle.
module uart_rx_hold
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  overrun,
  output logic                  drop
);

  // A new byte is lost only when the held byte is neither empty nor consumed now.
  assign drop = load && valid && !ready;

  // Load / consume / overrun register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= drop;
      if (load && !drop) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Serial-to-parallel UART receive stage: one bit per clock, MSB first,
// stop-bit check, break recovery, and a one-entry output holding register.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  framing_error,
  output logic                  overrun,
  output logic [7:0]            error_count
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  rx_state_t             state;
  rx_state_t             state_next;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  shift_en;
  logic                  frame_good;
  logic                  frame_bad;
  logic                  drop;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; RECOVER holds off start detection through a break.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!rx) state_next = DATA;
      DATA:    if (bit_cnt == LAST_BIT) state_next = STOP;
      STOP:    state_next = rx ? IDLE : RECOVER;
      RECOVER: if (rx) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded FSM outputs.
  always_comb begin
    shift_en   = (state == DATA);
    frame_good = (state == STOP) && rx;
    frame_bad  = (state == STOP) && !rx;
  end

  // Shift register and bit counter; counter is cleared outside DATA.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= {shreg[DATA_WIDTH-2:0], rx};
      bit_cnt <= bit_cnt + 1'b1;
    end else begin
      bit_cnt <= '0;
    end
  end

  // Framing-error pulse and saturating error counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      framing_error <= 1'b0;
      error_count   <= '0;
    end else begin
      framing_error <= frame_bad;
      if ((frame_bad || drop) && (error_count != '1))
        error_count <= error_count + 8'd1;
    end
  end

  uart_rx_hold #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (frame_good),
    .load_data (shreg),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .overrun   (overrun),
    .drop      (drop)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver (DATA_WIDTH = 8).
module tb_uart_receiver;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       overrun;
  logic [7:0] error_count;

  int total = 0;
  int bad   = 0;

  // Monitor state: handshakes seen at rising edges, pulse counts.
  int         cyc = 0;
  logic [7:0] beat_data[$];
  int         beat_cyc[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         last_start = 0;

  uart_receiver #(.DATA_WIDTH(8)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .rx            (rx),
    .data          (data),
    .valid         (valid),
    .ready         (ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .error_count   (error_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (valid && ready) begin
      beat_data.push_back(data);
      beat_cyc.push_back(cyc);
    end
    if (framing_error) fe_cnt = fe_cnt + 1;
    if (overrun)       ov_cnt = ov_cnt + 1;
    cyc = cyc + 1;
  end

  task automatic step(input logic b);
    @(negedge CLK);
    rx = b;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    step(1'b0);
    last_start = cyc;
    for (int i = 7; i >= 0; i--) step(d[i]);
    step(stop_bit);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    @(negedge CLK);
    beat_data.delete();
    beat_cyc.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", framing_error); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b want=0", overrun); end
    total++; if (error_count !== 8'd0) begin bad++; $display("FAIL reset_ec got=%0d want=0", error_count); end
  endtask

  task automatic test_single_a5();
    logic [11:0] seq;
    do_reset();
    ready = 1'b1;
    seq = 12'b1101_0100_1011;  // 1,1,0,1,0,1,0,0,1,0,1,1
    for (int i = 11; i >= 0; i--) begin
      step(seq[i]);
      if (i == 9) last_start = cyc;
    end
    repeat (3) step(1'b1);
    total++; if (beat_data.size() != 1) begin bad++; $display("FAIL a5_beats got=%0d want=1", beat_data.size()); end
    total++; if (beat_data[0] !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", beat_data[0]); end
    total++; if (beat_cyc[0] - last_start != 10) begin bad++; $display("FAIL a5_latency got=%0d want=10", beat_cyc[0] - last_start); end
    total++; if (fe_cnt + ov_cnt != 0) begin bad++; $display("FAIL a5_err_pulses got=%0d want=0", fe_cnt + ov_cnt); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL a5_valid_after got=%b want=0", valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready = 1'b1;
    step(1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    repeat (3) step(1'b1);
    total++; if (beat_data.size() != 2) begin bad++; $display("FAIL b2b_beats got=%0d want=2", beat_data.size()); end
    total++; if (beat_data[0] !== 8'h3C) begin bad++; $display("FAIL b2b_data0 got=%h want=3c", beat_data[0]); end
    total++; if (beat_data[1] !== 8'hC3) begin bad++; $display("FAIL b2b_data1 got=%h want=c3", beat_data[1]); end
    total++; if (beat_cyc[1] - beat_cyc[0] != 10) begin bad++; $display("FAIL b2b_spacing got=%0d want=10", beat_cyc[1] - beat_cyc[0]); end
    total++; if (error_count !== 8'd0) begin bad++; $display("FAIL b2b_ec got=%0d want=0", error_count); end
  endtask

  task automatic test_framing();
    do_reset();
    ready = 1'b1;
    step(1'b1);
    send_frame(8'h55, 1'b0);
    repeat (5) step(1'b0);
    repeat (3) step(1'b1);
    total++; if (beat_data.size() != 0) begin bad++; $display("FAIL fe_no_valid got=%0d beats want=0", beat_data.size()); end
    total++; if (fe_cnt != 1) begin bad++; $display("FAIL fe_pulse got=%0d cycles want=1", fe_cnt); end
    send_frame(8'h81, 1'b1);
    repeat (3) step(1'b1);
    total++; if (beat_data.size() != 1) begin bad++; $display("FAIL fe_next_beats got=%0d want=1", beat_data.size()); end
    total++; if (beat_data[0] !== 8'h81) begin bad++; $display("FAIL fe_next_data got=%h want=81", beat_data[0]); end
    total++; if (error_count !== 8'd1) begin bad++; $display("FAIL fe_ec got=%0d want=1", error_count); end
  endtask

  task automatic test_overrun();
    do_reset();
    step(1'b1);
    send_frame(8'h11, 1'b1);
    repeat (2) step(1'b1);
    send_frame(8'h22, 1'b1);
    repeat (2) step(1'b1);
    #1;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", valid); end
    total++; if (data !== 8'h11) begin bad++; $display("FAIL ovr_data got=%h want=11", data); end
    total++; if (ov_cnt != 1) begin bad++; $display("FAIL ovr_pulse got=%0d want=1", ov_cnt); end
    total++; if (error_count !== 8'd1) begin bad++; $display("FAIL ovr_ec got=%0d want=1", error_count); end
    @(negedge CLK); ready = 1'b1;
    @(negedge CLK); ready = 1'b0;
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovr_drain_valid got=%b want=0", valid); end
    total++; if (data !== 8'h11) begin bad++; $display("FAIL ovr_data_hold got=%h want=11", data); end
    total++; if (beat_data.size() != 1 || beat_data[0] !== 8'h11) begin bad++; $display("FAIL ovr_consumed got=%0d beats want=1 of 11", beat_data.size()); end
  endtask

  task automatic test_ready_at_stop();
    logic [7:0] d;
    do_reset();
    step(1'b1);
    send_frame(8'h11, 1'b1);
    repeat (2) step(1'b1);
    d = 8'h22;
    step(1'b0);
    for (int i = 7; i >= 0; i--) step(d[i]);
    @(negedge CLK); rx = 1'b1; ready = 1'b1;
    @(negedge CLK); ready = 1'b0;
    #1;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL ras_valid got=%b want=1", valid); end
    total++; if (data !== 8'h22) begin bad++; $display("FAIL ras_data got=%h want=22", data); end
    total++; if (ov_cnt != 0) begin bad++; $display("FAIL ras_overrun got=%0d want=0", ov_cnt); end
    total++; if (error_count !== 8'd0) begin bad++; $display("FAIL ras_ec got=%0d want=0", error_count); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    do_reset();
    step(1'b1);
    send_frame(8'h77, 1'b1);
    step(1'b1);
    d = 8'hF0;
    step(1'b0);
    for (int i = 7; i >= 4; i--) step(d[i]);
    @(negedge CLK); RESET = 1'b1; rx = 1'b1;
    #1;
    total++; if (data !== 8'h00 || valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out got=%h/%b want=00/0", data, valid); end
    total++; if (framing_error !== 1'b0 || overrun !== 1'b0 || error_count !== 8'd0) begin bad++; $display("FAIL mid_rst_err got=%b/%b/%0d want=0/0/0", framing_error, overrun, error_count); end
    @(negedge CLK); RESET = 1'b0; ready = 1'b1;
    repeat (12) step(1'b1);
    total++; if (beat_data.size() != 0 || fe_cnt != 0) begin bad++; $display("FAIL mid_rst_residue got=%0d beats %0d fe want=0 0", beat_data.size(), fe_cnt); end
    send_frame(8'h0F, 1'b1);
    repeat (3) step(1'b1);
    total++; if (beat_data.size() != 1 || beat_data[0] !== 8'h0F) begin bad++; $display("FAIL mid_rst_next got=%0d beats data=%h want=1 0f", beat_data.size(), beat_data[0]); end
  endtask

  task automatic test_saturation();
    do_reset();
    step(1'b1);
    for (int n = 0; n < 260; n++) begin
      send_frame(8'h00, 1'b0);
      step(1'b1);
    end
    repeat (2) step(1'b1);
    total++; if (fe_cnt != 260) begin bad++; $display("FAIL sat_fe_pulses got=%0d want=260", fe_cnt); end
    total++; if (error_count !== 8'd255) begin bad++; $display("FAIL sat_ec got=%0d want=255", error_count); end
  endtask

  initial begin
    RESET = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_framing();
    test_overrun();
    test_ready_at_stop();
    test_reset_midframe();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
